disp_enc: RTL and testbench

- Converts a 16-bit binary value into four 8-bit seven-segment patterns for the 4-digit display multiplexer that drives the board display.
- Decimal mode uses an iterative shift-add-3 (double-dabble) converter. Hex mode maps nibbles directly.
- Uses a load/busy/done handshake. Segment outputs are registered and hold the last result until the next conversion completes.
- Feeds the multiplexer's a..d inputs; a is the least-significant digit.

---
 rtl/disp_enc.sv | 199 +++++++++++++++++++
 tb/tb_disp_enc.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/disp_enc.sv
// ---------------------------------------------------------------------------
// disp_enc
//   Converts a 16-bit binary value into four seven-segment patterns for the
//   4-digit display multiplexer. Decimal mode runs an iterative shift-add-3
//   (double-dabble) conversion. Hex mode runs the same shifter without the
//   add-3 correction, so the nibbles land in place and latency is identical.
//
//   Ports:
//     clock     in   1   system clock, rising edge
//     reset_n   in   1   asynchronous active-low reset
//     value     in  16   binary value, sampled at load
//     hex_mode  in   1   1 = hexadecimal, 0 = decimal, sampled at load
//     dp        in   4   per-digit decimal point (bit0 = digit a), sampled at load
//     load      in   1   start request, honoured only when idle
//     busy      out  1   conversion in progress
//     done      out  1   one-cycle pulse when a..d update
//     ovf       out  1   decimal value > 9999, held with the result
//     a..d      out  8   digit 0 (LS) .. digit 3 (MS) segment patterns
//                        (bit0..6 = segments a..g, bit7 = dp)
// ---------------------------------------------------------------------------
module disp_enc #(
    parameter bit BLANK_LZ       = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] value,
    input  logic        hex_mode,
    input  logic [3:0]  dp,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic [7:0]  a,
    output logic [7:0]  b,
    output logic [7:0]  c,
    output logic [7:0]  d
);

    localparam logic [7:0] SEG_INV = {8{SEG_ACTIVE_LOW}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_ENC  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [4:0]  r_cnt;
    logic [15:0] r_shift;
    logic [19:0] r_bcd;
    logic [19:0] w_bcd_adj;
    logic        r_hex;
    logic [3:0]  r_dp;
    logic        r_done;
    logic        r_ovf;
    logic [7:0]  r_seg [4];
    logic [7:0]  w_seg [4];
    logic [3:1]  w_zero;
    logic [3:0]  w_blank;
    logic        w_ovf;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            4'hF: g = 7'h71;
            default: g = 7'h00;
        endcase
        return g;
    endfunction

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (load) w_state_next = S_CONV;
            // r_cnt == 15 means this edge performs the 16th iteration
            S_CONV:  if (r_cnt == 5'd15) w_state_next = S_ENC;
            S_ENC:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Add-3 correction per BCD digit; bypassed in hex mode so the shifter
    // simply moves the raw value into r_bcd[15:0].
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_add3
            assign w_bcd_adj[4*gi +: 4] = (!r_hex && (r_bcd[4*gi +: 4] >= 4'd5))
                                        ? r_bcd[4*gi +: 4] + 4'd3
                                        : r_bcd[4*gi +: 4];
        end
    endgenerate

    // Digit 4 is nonzero only when the decimal value exceeds 9999.
    assign w_ovf = !r_hex && (r_bcd[19:16] != 4'd0);

    // -----------------------------------------------------------------------
    // Glyph selection with leading-zero blanking. A digit is blank when it and
    // every more-significant digit are zero; digit a is never blanked.
    // -----------------------------------------------------------------------
    generate
        for (gi = 0; gi < 4; gi++) begin : g_enc
            if (gi == 0) begin : g_lsd
                assign w_blank[gi] = 1'b0;
            end else begin : g_upper
                assign w_zero[gi]  = (r_bcd[4*gi +: 4] == 4'd0);
                assign w_blank[gi] = BLANK_LZ && (&w_zero[3:gi]);
            end
            assign w_seg[gi] = {r_dp[gi],
                                w_ovf        ? 7'h40 :
                                w_blank[gi]  ? 7'h00 :
                                glyph(r_bcd[4*gi +: 4])};
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Datapath and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= 5'd0;
            r_shift <= 16'd0;
            r_bcd   <= 20'd0;
            r_hex   <= 1'b0;
            r_dp    <= 4'd0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                r_seg[k] <= SEG_INV;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_shift <= value;
                        r_hex   <= hex_mode;
                        r_dp    <= dp;
                        r_bcd   <= 20'd0;
                        r_cnt   <= 5'd0;
                    end
                end
                S_CONV: begin
                    // {bcd, shift} <<= 1 after the correction step
                    r_bcd   <= {w_bcd_adj[18:0], r_shift[15]};
                    r_shift <= {r_shift[14:0], 1'b0};
                    r_cnt   <= r_cnt + 5'd1;
                end
                S_ENC: begin
                    r_done <= 1'b1;
                    r_ovf  <= w_ovf;
                    for (int k = 0; k < 4; k++) begin
                        r_seg[k] <= w_seg[k] ^ SEG_INV;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign ovf  = r_ovf;
    assign a    = r_seg[0];
    assign b    = r_seg[1];
    assign c    = r_seg[2];
    assign d    = r_seg[3];

endmodule

// File: tb/tb_disp_enc.sv
// ---------------------------------------------------------------------------
// tb_disp_enc
//   Self-checking bench for disp_enc. Two instances share the stimulus: one
//   with active-high segments, one with SEG_ACTIVE_LOW = 1. Expected patterns
//   come from an arithmetic model (division/modulo by the radix).
// ---------------------------------------------------------------------------
module tb_disp_enc;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] value   = 16'd0;
    logic        hex_mode = 1'b0;
    logic [3:0]  dp      = 4'd0;
    logic        load    = 1'b0;

    logic        busy, done, ovf;
    logic [7:0]  a, b, c, d;
    logic        busy_al, done_al, ovf_al;
    logic [7:0]  a_al, b_al, c_al, d_al;

    int total = 0;
    int bad   = 0;

    logic [32:0] prev_exp;

    logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    disp_enc #(.BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b0)) u_dut (
        .clock(clock), .reset_n(reset_n), .value(value), .hex_mode(hex_mode),
        .dp(dp), .load(load), .busy(busy), .done(done), .ovf(ovf),
        .a(a), .b(b), .c(c), .d(d)
    );

    disp_enc #(.BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b1)) u_dut_al (
        .clock(clock), .reset_n(reset_n), .value(value), .hex_mode(hex_mode),
        .dp(dp), .load(load), .busy(busy_al), .done(done_al), .ovf(ovf_al),
        .a(a_al), .b(b_al), .c(c_al), .d(d_al)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns {ovf, d, c, b, a} for the active-high instance.
    function automatic logic [32:0] model(input int v, input bit hx, input logic [3:0] dpv);
        logic [32:0] r;
        int  base = hx ? 16 : 10;
        int  pw   = 1;
        bit  ov   = !hx && (v > 9999);
        logic [7:0] s;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            if (ov)                 s = 8'h40;
            else if (k > 0 && v < pw) s = 8'h00;
            else                    s = {1'b0, glyph_tab[(v / pw) % base]};
            s[7] = s[7] | dpv[k];
            r[8*k +: 8] = s;
            pw = pw * base;
        end
        r[32] = ov;
        return r;
    endfunction

    task automatic check_outputs(input string tag, input logic [32:0] e);
        check({tag, "_a"}, a, e[7:0]);
        check({tag, "_b"}, b, e[15:8]);
        check({tag, "_c"}, c, e[23:16]);
        check({tag, "_d"}, d, e[31:24]);
        check({tag, "_ovf"}, ovf, e[32]);
        check({tag, "_al"}, {d_al, c_al, b_al, a_al}, ~e[31:0]);
        check({tag, "_al_ovf"}, ovf_al, e[32]);
    endtask

    // One conversion. When poke is set, a load for a different value and mode
    // is pulsed mid-conversion and must be ignored.
    task automatic run_conv(input logic [15:0] v, input bit hx, input logic [3:0] dpv, input bit poke);
        int  nbusy  = 0;
        bit  seen   = 0;
        bit  stable = 1;
        logic [32:0] e;
        @(negedge clock);
        value = v; hex_mode = hx; dp = dpv; load = 1'b1;
        @(posedge clock);
        #1 load = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            if (done) begin
                seen = 1;
            end else begin
                if (busy) nbusy++;
                if ({ovf, d, c, b, a} !== prev_exp) stable = 0;
                load = (poke && i == 5);
                if (poke && i == 5) begin
                    value = ~v; hex_mode = !hx; dp = ~dpv;
                end
            end
        end
        load = 1'b0;
        e = model(int'(v), hx, dpv);
        check("done_seen", seen, 1);
        check("busy_cycles", nbusy, 17);
        check("held_during_conv", stable, 1);
        check("busy_at_done", busy, 0);
        check_outputs($sformatf("v%0h_%s", v, hx ? "hex" : "dec"), e);
        $display("conv value=%0d hex=%0b dp=%b -> d=%02h c=%02h b=%02h a=%02h ovf=%0b",
                 v, hx, dpv, d, c, b, a, ovf);
        @(negedge clock);
        check("done_one_cycle", done, 0);
        prev_exp = e;
    endtask

    initial begin
        logic [32:0] e1, e2;
        int gap;
        bit seen;
        prev_exp = '0;

        // Asynchronous reset: outputs must be at reset values before any edge.
        #2 reset_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        check("rst_seg", {d, c, b, a}, 32'h0);
        check("rst_seg_al", {d_al, c_al, b_al, a_al}, 32'hFFFF_FFFF);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        // Directed cases
        run_conv(16'd1234,  1'b0, 4'b0000, 1'b0);
        run_conv(16'd7,     1'b0, 4'b0000, 1'b0);
        run_conv(16'd0,     1'b0, 4'b0000, 1'b0);
        run_conv(16'd1005,  1'b0, 4'b0000, 1'b0);
        run_conv(16'd9999,  1'b0, 4'b0000, 1'b0);
        run_conv(16'd10000, 1'b0, 4'b0000, 1'b0);
        run_conv(16'd65535, 1'b0, 4'b1010, 1'b0);
        run_conv(16'hBEEF,  1'b1, 4'b0000, 1'b0);
        run_conv(16'h00A0,  1'b1, 4'b0000, 1'b0);
        run_conv(16'h1234,  1'b1, 4'b0100, 1'b0);
        run_conv(16'd8,     1'b0, 4'b0000, 1'b0);
        run_conv(16'd42,    1'b0, 4'b1000, 1'b0);
        run_conv(16'd4321,  1'b0, 4'b0000, 1'b1);

        // load held high: back-to-back conversions, value changed during the
        // first one is picked up only by the second.
        @(negedge clock);
        value = 16'd5678; hex_mode = 1'b0; dp = 4'b0001; load = 1'b1;
        @(posedge clock);
        #1 value = 16'hC0DE; hex_mode = 1'b1; dp = 4'b0000;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            if (done) seen = 1;
        end
        check("hold_done1", seen, 1);
        e1 = model(5678, 1'b0, 4'b0001);
        check_outputs("hold_first", e1);
        seen = 0;
        gap  = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            gap++;
            if (done) seen = 1;
        end
        load = 1'b0;
        check("hold_done2", seen, 1);
        check("hold_gap", gap, 18);
        e2 = model(16'hC0DE, 1'b1, 4'b0000);
        check_outputs("hold_second", e2);
        $display("hold-load second conv -> d=%02h c=%02h b=%02h a=%02h", d, c, b, a);
        prev_exp = e2;
        @(negedge clock);
        check("hold_idle", busy, 0);

        // Randomised conversions
        for (int n = 0; n < 30; n++) begin
            logic [15:0] rv;
            int sel;
            sel = $urandom_range(0, 3);
            case (sel)
                0: rv = 16'($urandom_range(0, 99));
                1: rv = 16'($urandom_range(9990, 10010));
                default: rv = 16'($urandom);
            endcase
            run_conv(rv, 1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)));
        end

        // Reset at cycle 8 of the conversion: aborted, no done pulse.
        @(negedge clock);
        value = 16'd1234; hex_mode = 1'b0; dp = 4'b1111; load = 1'b1;
        @(posedge clock);
        #1 load = 1'b0;
        repeat (8) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_ovf", ovf, 0);
        check("abort_seg", {d, c, b, a}, 32'h0);
        check("abort_seg_al", {d_al, c_al, b_al, a_al}, 32'hFFFF_FFFF);
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clock);
            if (done || busy) seen = 1;
        end
        check("abort_no_done", seen, 0);
        check("abort_seg_after", {d, c, b, a}, 32'h0);
        prev_exp = '0;

        // Conversion after the abort works normally.
        run_conv(16'd90, 1'b0, 4'b0000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
